// File: rtl/ip_hdr_pkg.sv
// IPv4 header generator shared definitions: header constants, command
// encodings, FSM states, field byte offsets and the header byte mux.
package ip_hdr_pkg;

    localparam int          IPH_LEN = 20;
    localparam logic [7:0]  VER_IHL = 8'h45;

    localparam logic [1:0]  CMD_NOP    = 2'd0;
    localparam logic [1:0]  CMD_CLR_ID = 2'd1;
    localparam logic [1:0]  CMD_SET_DF = 2'd2;
    localparam logic [1:0]  CMD_CLR_DF = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FOLD,
        WRITE
    } state_t;

    localparam logic [4:0]  OFS_VER   = 5'd0;
    localparam logic [4:0]  OFS_TOS   = 5'd1;
    localparam logic [4:0]  OFS_LEN   = 5'd2;
    localparam logic [4:0]  OFS_ID    = 5'd4;
    localparam logic [4:0]  OFS_FLAGS = 5'd6;
    localparam logic [4:0]  OFS_TTL   = 5'd8;
    localparam logic [4:0]  OFS_PROTO = 5'd9;
    localparam logic [4:0]  OFS_CSUM  = 5'd10;
    localparam logic [4:0]  OFS_SRC   = 5'd12;
    localparam logic [4:0]  OFS_DST   = 5'd16;

    // Per-header snapshot taken at trigger time.
    typedef struct packed {
        logic [15:0] total_len;
        logic [31:0] src;
        logic [15:0] id;
        logic        df;
    } snap_t;

    // Header byte at index idx; indices past the header return 0.
    function automatic logic [7:0] hdr_byte(
        input logic [4:0]  idx,
        input snap_t       s,
        input logic [15:0] csum,
        input logic [31:0] dst,
        input logic [7:0]  ttl,
        input logic [7:0]  proto
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            OFS_VER:         b = VER_IHL;
            OFS_TOS:         b = 8'h00;
            OFS_LEN:         b = s.total_len[15:8];
            OFS_LEN + 5'd1:  b = s.total_len[7:0];
            OFS_ID:          b = s.id[15:8];
            OFS_ID + 5'd1:   b = s.id[7:0];
            OFS_FLAGS:       b = s.df ? 8'h40 : 8'h00;
            OFS_FLAGS + 5'd1: b = 8'h00;
            OFS_TTL:         b = ttl;
            OFS_PROTO:       b = proto;
            OFS_CSUM:        b = csum[15:8];
            OFS_CSUM + 5'd1: b = csum[7:0];
            OFS_SRC:         b = s.src[31:24];
            OFS_SRC + 5'd1:  b = s.src[23:16];
            OFS_SRC + 5'd2:  b = s.src[15:8];
            OFS_SRC + 5'd3:  b = s.src[7:0];
            OFS_DST:         b = dst[31:24];
            OFS_DST + 5'd1:  b = dst[23:16];
            OFS_DST + 5'd2:  b = dst[15:8];
            OFS_DST + 5'd3:  b = dst[7:0];
            default:         b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ip_header_gen_csum.sv
// ip_csum: one's-complement checksum accumulator.
// Ports: clk, rst (sync high), clr, add, word in; csum = ~fold(fold(acc)).
module ip_csum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] csum
);

    // 20 bits hold the sum of ten 16-bit words without overflow.
    logic [19:0] acc;
    logic [16:0] s1;
    logic [16:0] s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + {4'd0, word};
        end
    end

    // Two folds absorb every end-around carry.
    always_comb begin
        s1   = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        s2   = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        csum = ~s2[15:0];
    end

endmodule

// File: rtl/ip_header_gen.sv
// ip_header_gen: streams a 20-byte IPv4 header, one byte per clock.
// Ports: i_clk, i_rst (sync high), i_trig, i_data_length, i_ip0..3, i_cmd;
// o_iph_idx, o_iph_byte, o_wr_iph_en, o_ready.
// Macro IPH_ID_AUTOINC_EN: builds the auto-incrementing ID register.
module ip_header_gen
    import ip_hdr_pkg::*;
#(
    parameter logic [31:0] DST_IP = 32'hC0A80102,
    parameter logic [7:0]  TTL    = 8'd64,
    parameter logic [7:0]  PROTO  = 8'd17
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trig,
    input  logic [15:0] i_data_length,
    input  logic [7:0]  i_ip0,
    input  logic [7:0]  i_ip1,
    input  logic [7:0]  i_ip2,
    input  logic [7:0]  i_ip3,
    input  logic [1:0]  i_cmd,
    output logic [4:0]  o_iph_idx,
    output logic [7:0]  o_iph_byte,
    output logic        o_wr_iph_en,
    output logic        o_ready
);

    state_t      state;
    logic [3:0]  cnt;
    snap_t       snap;
    logic [15:0] csum_q;
    logic [15:0] csum_out;
    logic [15:0] word;
    logic [15:0] id_cur;
    logic        df_q;
    logic        csum_clr;
    logic        csum_add;
    logic        last_wr;

    assign last_wr  = (state == WRITE) && (o_iph_idx == 5'd19);
    assign csum_clr = (state == IDLE) && i_trig;
    assign csum_add = (state == CALC);

    // Checksum field reads as zero while summing.
    always_comb begin
        word = {hdr_byte({cnt, 1'b0}, snap, 16'h0000, DST_IP, TTL, PROTO),
                hdr_byte({cnt, 1'b1}, snap, 16'h0000, DST_IP, TTL, PROTO)};
    end

    ip_csum u_csum (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (csum_clr),
        .add  (csum_add),
        .word (word),
        .csum (csum_out)
    );

`ifdef IPH_ID_AUTOINC_EN
    logic [15:0] id_q;

    // Clear beats the end-of-header increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q <= '0;
        end else if (i_cmd == CMD_CLR_ID) begin
            id_q <= '0;
        end else if (last_wr) begin
            id_q <= id_q + 16'd1;
        end
    end

    assign id_cur = id_q;
`else
    assign id_cur = 16'h0000;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            df_q <= 1'b0;
        end else if (i_cmd == CMD_SET_DF) begin
            df_q <= 1'b1;
        end else if (i_cmd == CMD_CLR_DF) begin
            df_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            snap        <= '0;
            csum_q      <= '0;
            o_ready     <= 1'b1;
            o_wr_iph_en <= 1'b0;
            o_iph_idx   <= '0;
            o_iph_byte  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_trig) begin
                        snap.total_len <= i_data_length + 16'd20;
                        snap.src       <= {i_ip0, i_ip1, i_ip2, i_ip3};
                        snap.id        <= id_cur;
                        snap.df        <= df_q;
                        cnt            <= '0;
                        o_ready        <= 1'b0;
                        state          <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    csum_q      <= csum_out;
                    o_wr_iph_en <= 1'b1;
                    o_iph_idx   <= 5'd0;
                    o_iph_byte  <= hdr_byte(5'd0, snap, csum_out,
                                            DST_IP, TTL, PROTO);
                    state       <= WRITE;
                end
                WRITE: begin
                    if (o_iph_idx == 5'd19) begin
                        o_wr_iph_en <= 1'b0;
                        o_ready     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        o_iph_idx  <= o_iph_idx + 5'd1;
                        o_iph_byte <= hdr_byte(o_iph_idx + 5'd1, snap,
                                               csum_q, DST_IP, TTL, PROTO);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_gen.sv
// Bench for ip_header_gen: behavioural header model checked every cycle,
// directed scenarios with literal header bytes, then random traffic.
module tb_ip_header_gen;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_trig = 1'b0;
    logic [15:0] i_data_length = '0;
    logic [7:0]  i_ip0 = '0, i_ip1 = '0, i_ip2 = '0, i_ip3 = '0;
    logic [1:0]  i_cmd = '0;
    logic [4:0]  o_iph_idx;
    logic [7:0]  o_iph_byte;
    logic        o_wr_iph_en;
    logic        o_ready;

    always #5 clk = ~clk;

    ip_header_gen dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_trig        (i_trig),
        .i_data_length (i_data_length),
        .i_ip0         (i_ip0),
        .i_ip1         (i_ip1),
        .i_ip2         (i_ip2),
        .i_ip3         (i_ip3),
        .i_cmd         (i_cmd),
        .o_iph_idx     (o_iph_idx),
        .o_iph_byte    (o_iph_byte),
        .o_wr_iph_en   (o_wr_iph_en),
        .o_ready       (o_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_active = 0;
    int          m_t0 = 0;
    logic [15:0] m_id = '0;
    bit          m_df = 0;
    logic [7:0]  m_hdr [20];
    bit          exp_ready = 1;
    bit          exp_wr = 0;
    logic [4:0]  exp_idx = '0;
    logic [7:0]  exp_byte = '0;

    function automatic void build(input logic [15:0] dlen,
                                  input logic [31:0] src,
                                  input logic [15:0] id, input bit df);
        logic [15:0] tl;
        int unsigned sum;
        logic [15:0] c;
        tl = dlen + 16'd20;
        m_hdr[0] = 8'h45;  m_hdr[1] = 8'h00;
        m_hdr[2] = tl[15:8]; m_hdr[3] = tl[7:0];
        m_hdr[4] = id[15:8]; m_hdr[5] = id[7:0];
        m_hdr[6] = df ? 8'h40 : 8'h00; m_hdr[7] = 8'h00;
        m_hdr[8] = 8'd64;  m_hdr[9] = 8'd17;
        m_hdr[10] = 8'h00; m_hdr[11] = 8'h00;
        m_hdr[12] = src[31:24]; m_hdr[13] = src[23:16];
        m_hdr[14] = src[15:8];  m_hdr[15] = src[7:0];
        m_hdr[16] = 8'hC0; m_hdr[17] = 8'hA8;
        m_hdr[18] = 8'h01; m_hdr[19] = 8'h02;
        sum = 0;
        for (int i = 0; i < 10; i++)
            sum += {16'd0, m_hdr[2*i], m_hdr[2*i+1]};
        while ((sum >> 16) != 0)
            sum = (sum & 32'hFFFF) + (sum >> 16);
        c = ~sum[15:0];
        m_hdr[10] = c[15:8];
        m_hdr[11] = c[7:0];
    endfunction

    always @(posedge clk) begin
        bit busy;
        cyc++;
        if (i_rst) begin
            m_active = 0;
            m_id = '0;
            m_df = 0;
            exp_idx = '0;
            exp_byte = '0;
        end else begin
            busy = m_active;
            if (m_active && (cyc - m_t0) == 31) begin
                m_active = 0;
`ifdef IPH_ID_AUTOINC_EN
                m_id = m_id + 16'd1;
`endif
            end
            if (!busy && i_trig) begin
                build(i_data_length, {i_ip0, i_ip1, i_ip2, i_ip3},
                      m_id, m_df);
                m_active = 1;
                m_t0 = cyc;
            end
            case (i_cmd)
`ifdef IPH_ID_AUTOINC_EN
                2'd1: m_id = '0;
`endif
                2'd2: m_df = 1;
                2'd3: m_df = 0;
                default: ;
            endcase
        end
        exp_ready = !m_active;
        exp_wr = m_active && (cyc - m_t0) >= 11;
        if (exp_wr) begin
            exp_idx = 5'(cyc - m_t0 - 11);
            exp_byte = m_hdr[exp_idx];
        end
    end

    // Compare process and capture of written bytes.
    logic [7:0] cap [20];
    int         n_wr = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("ready", o_ready, exp_ready);
            check("wr_en", o_wr_iph_en, exp_wr);
            check("idx", o_iph_idx, exp_idx);
            check("byte", o_iph_byte, exp_byte);
        end
        if (o_wr_iph_en) begin
            cap[o_iph_idx] = o_iph_byte;
            n_wr++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [15:0] dlen, input logic [31:0] src);
        i_data_length = dlen;
        {i_ip0, i_ip1, i_ip2, i_ip3} = src;
        i_trig = 1'b1;
        tick(1);
        i_trig = 1'b0;
    endtask

    task automatic cmd_pulse(input logic [1:0] c);
        i_cmd = c;
        tick(1);
        i_cmd = 2'd0;
    endtask

    task automatic run_hdr(input string name, input logic [15:0] dlen,
                           input logic [7:0] exp [20]);
        n_wr = 0;
        fire(dlen, 32'hC0A801FD);
        tick(34);
        check({name, "_count"}, n_wr, 20);
        for (int i = 0; i < 20; i++)
            check($sformatf("%s_b%0d", name, i), cap[i], exp[i]);
    endtask

    logic [7:0] s1 [20] = '{8'h45, 8'h00, 8'h03, 8'h34, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h40, 8'h11, 8'hF3, 8'h69,
                            8'hC0, 8'hA8, 8'h01, 8'hFD, 8'hC0, 8'hA8,
                            8'h01, 8'h02};
`ifdef IPH_ID_AUTOINC_EN
    logic [7:0] s2 [20] = '{8'h45, 8'h00, 8'h03, 8'h34, 8'h00, 8'h01,
                            8'h00, 8'h00, 8'h40, 8'h11, 8'hF3, 8'h68,
                            8'hC0, 8'hA8, 8'h01, 8'hFD, 8'hC0, 8'hA8,
                            8'h01, 8'h02};
`else
    logic [7:0] s2 [20] = '{8'h45, 8'h00, 8'h03, 8'h34, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h40, 8'h11, 8'hF3, 8'h69,
                            8'hC0, 8'hA8, 8'h01, 8'hFD, 8'hC0, 8'hA8,
                            8'h01, 8'h02};
`endif
    logic [7:0] s3 [20] = '{8'h45, 8'h00, 8'h03, 8'h34, 8'h00, 8'h00,
                            8'h40, 8'h00, 8'h40, 8'h11, 8'hB3, 8'h69,
                            8'hC0, 8'hA8, 8'h01, 8'hFD, 8'hC0, 8'hA8,
                            8'h01, 8'h02};

    initial begin
        bit found;
        tick(3);
        i_rst = 1'b0;
        check("rst_ready", o_ready, 1);
        check("rst_wr", o_wr_iph_en, 0);
        tick(2);

        run_hdr("s1", 16'd800, s1);
        run_hdr("s2", 16'd800, s2);
        cmd_pulse(2'd1);
        run_hdr("s4", 16'd800, s1);

        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        cmd_pulse(2'd2);
        run_hdr("s3", 16'd800, s3);
        cmd_pulse(2'd3);

        // Ignored triggers mid-header, accepted in the first ready cycle.
        n_wr = 0;
        fire(16'd100, 32'h0A000001);
        tick(4);
        i_trig = 1'b1; tick(1); i_trig = 1'b0;
        tick(14);
        i_trig = 1'b1; tick(1); i_trig = 1'b0;
        tick(11);
        check("s5_ready_edge", o_ready, 1);
        i_trig = 1'b1; tick(1); i_trig = 1'b0;
        check("s5_count", n_wr, 20);
        check("s5_accepted", o_ready, 0);
        tick(34);

        // Reset in the middle of the write phase.
        fire(16'd800, 32'hC0A801FD);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (o_wr_iph_en && o_iph_idx == 5'd7) found = 1;
        end
        check("s6_reach_idx7", found, 1);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        check("s6_wr_off", o_wr_iph_en, 0);
        check("s6_ready", o_ready, 1);
        run_hdr("s6", 16'd800, s1);

        n_wr = 0;
        fire(16'hFFF0, 32'hC0A801FD);
        tick(34);
        check("wrap_len_hi", cap[2], 8'h00);
        check("wrap_len_lo", cap[3], 8'h04);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            i_trig = ($urandom_range(0, 7) == 0);
            i_cmd = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd0;
            i_rst = ($urandom_range(0, 299) == 0);
            i_data_length = 16'($urandom);
            {i_ip0, i_ip1, i_ip2, i_ip3} = $urandom;
            tick(1);
        end
        i_trig = 1'b0;
        i_cmd = 2'd0;
        i_rst = 1'b0;
        tick(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
